// File: rtl/prbs_pkg.sv
// Shared PRBS definitions: polynomial modes, per-mode tap/order tables and
// checker FSM states, used by the checker and the future generator.
package prbs_pkg;

  typedef enum logic [1:0] {
    PRBS7  = 2'd0,
    PRBS15 = 2'd1,
    PRBS23 = 2'd2,
    PRBS31 = 2'd3
  } prbs_mode_t;

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  localparam int unsigned HIST_W = 31;

  // History bit k holds the bit received k+1 valid cycles ago, so a term x^n
  // of the polynomial maps to history index n-1.
  localparam logic [4:0] PRBS_ORDER [4] = '{5'd7, 5'd15, 5'd23, 5'd31};
  localparam logic [4:0] PRBS_TAP_A [4] = '{5'd6, 5'd14, 5'd22, 5'd30};
  localparam logic [4:0] PRBS_TAP_B [4] = '{5'd5, 5'd13, 5'd17, 5'd27};

  function automatic logic [4:0] prbs_order(input logic [1:0] mode);
    return PRBS_ORDER[mode];
  endfunction

endpackage

// File: rtl/prbs_next_bit.sv
// Combinational PRBS predictor: next sequence bit from the 31-bit history
// (bit 0 = most recent) for the selected polynomial.
module prbs_next_bit
  import prbs_pkg::*;
(
  input  logic [HIST_W-1:0] hist_i,
  input  logic [1:0]        mode_i,
  output logic              bit_o
);

  always_comb begin
    bit_o = hist_i[PRBS_TAP_A[mode_i]] ^ hist_i[PRBS_TAP_B[mode_i]];
  end

endmodule

// File: rtl/prbs_lock_checker.sv
// Self-synchronising PRBS7/15/23/31 bit-error checker with SEED/VERIFY/LOCKED
// acquisition. Loss-of-lock window logic is built only with PRBS_LOCK_CHECKER_LOL_EN.
module prbs_lock_checker
  import prbs_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH   = 32,
  parameter int unsigned VERIFY_LEN    = 32,
  parameter int unsigned WINDOW_LEN    = 64,
  parameter int unsigned LOL_THRESHOLD = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             prbs_sel,
  input  logic                   clear,
  input  logic                   data_in,
  input  logic                   data_in_valid,
  output logic                   locked,
  output logic                   error_pulse,
  output logic [COUNT_WIDTH-1:0] total_bits,
  output logic [COUNT_WIDTH-1:0] total_bit_errors,
  output logic [15:0]            lol_count
);

  localparam int unsigned MW = $clog2(VERIFY_LEN + 1);

  chk_state_t             state_q, state_d;
  logic [HIST_W-1:0]      hist_q, hist_d;
  logic [4:0]             seed_cnt_q, seed_cnt_d;
  logic [MW-1:0]          match_cnt_q, match_cnt_d;
  logic [1:0]             sel_q, sel_d;
  logic                   err_pulse_q, err_pulse_d;
  logic [COUNT_WIDTH-1:0] bits_q, bits_d;
  logic [COUNT_WIDTH-1:0] errs_q, errs_d;
  logic                   bits_inc, errs_inc;
  logic                   pred_bit, mismatch, sel_change;
  logic [4:0]             order;

`ifdef PRBS_LOCK_CHECKER_LOL_EN
  localparam int unsigned WB = $clog2(WINDOW_LEN + 1);
  localparam int unsigned EB = $clog2(LOL_THRESHOLD + 1);

  logic [WB-1:0] win_bit_q, win_bit_d;
  logic [EB-1:0] win_err_q, win_err_d, win_err_inc;
  logic [15:0]   lol_q, lol_d;
  logic          lol_event;
`else
  logic          unused_cfg;
`endif

  prbs_next_bit u_next_bit (
    .hist_i (hist_q),
    .mode_i (sel_q),
    .bit_o  (pred_bit)
  );

  always_comb begin
    mismatch   = data_in ^ pred_bit;
    sel_change = (prbs_sel != sel_q);
    order      = prbs_order(sel_q);
  end

  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    seed_cnt_d  = seed_cnt_q;
    match_cnt_d = match_cnt_q;
    sel_d       = sel_q;
    err_pulse_d = 1'b0;
    bits_inc    = 1'b0;
    errs_inc    = 1'b0;
`ifdef PRBS_LOCK_CHECKER_LOL_EN
    win_bit_d   = win_bit_q;
    win_err_d   = win_err_q;
    win_err_inc = win_err_q;
    lol_event   = 1'b0;
`endif

    if (sel_change) begin
      // A new polynomial invalidates the history; the pending bit is dropped.
      state_d     = SEED;
      seed_cnt_d  = '0;
      match_cnt_d = '0;
      sel_d       = prbs_sel;
    end else if (data_in_valid) begin
      case (state_q)
        SEED: begin
          hist_d = {hist_q[HIST_W-2:0], data_in};
          if (seed_cnt_q == order - 5'd1) begin
            state_d    = VERIFY;
            seed_cnt_d = '0;
          end else begin
            seed_cnt_d = seed_cnt_q + 5'd1;
          end
        end

        VERIFY: begin
          if (!mismatch) begin
            hist_d = {hist_q[HIST_W-2:0], data_in};
            if (match_cnt_q == MW'(VERIFY_LEN - 1)) begin
              state_d     = LOCKED;
              match_cnt_d = '0;
`ifdef PRBS_LOCK_CHECKER_LOL_EN
              win_bit_d   = '0;
              win_err_d   = '0;
`endif
            end else begin
              match_cnt_d = match_cnt_q + MW'(1);
            end
          end else begin
            state_d     = SEED;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end
        end

        LOCKED: begin
          // Free-running: the received bit never enters the history here.
          hist_d      = {hist_q[HIST_W-2:0], pred_bit};
          bits_inc    = 1'b1;
          errs_inc    = mismatch;
          err_pulse_d = mismatch;
`ifdef PRBS_LOCK_CHECKER_LOL_EN
          win_err_inc = win_err_q + EB'(mismatch);
          if (mismatch && (win_err_inc == EB'(LOL_THRESHOLD))) begin
            lol_event   = 1'b1;
            state_d     = SEED;
            seed_cnt_d  = '0;
            match_cnt_d = '0;
          end
          if (win_bit_q == WB'(WINDOW_LEN - 1)) begin
            win_bit_d = '0;
            win_err_d = '0;
          end else begin
            win_bit_d = win_bit_q + WB'(1);
            win_err_d = win_err_inc;
          end
`endif
        end

        default: begin
          state_d = SEED;
        end
      endcase
    end
  end

  always_comb begin
    bits_d = bits_q;
    errs_d = errs_q;
    if (clear) begin
      bits_d = '0;
      errs_d = '0;
    end else begin
      if (bits_inc && (bits_q != '1)) begin
        bits_d = bits_q + COUNT_WIDTH'(1);
      end
      if (errs_inc && (errs_q != '1)) begin
        errs_d = errs_q + COUNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEED;
      hist_q      <= '0;
      seed_cnt_q  <= '0;
      match_cnt_q <= '0;
      sel_q       <= prbs_sel;
      err_pulse_q <= 1'b0;
      bits_q      <= '0;
      errs_q      <= '0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      seed_cnt_q  <= seed_cnt_d;
      match_cnt_q <= match_cnt_d;
      sel_q       <= sel_d;
      err_pulse_q <= err_pulse_d;
      bits_q      <= bits_d;
      errs_q      <= errs_d;
    end
  end

`ifdef PRBS_LOCK_CHECKER_LOL_EN
  always_comb begin
    lol_d = lol_q;
    if (lol_event && (lol_q != '1)) begin
      lol_d = lol_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      win_bit_q <= '0;
      win_err_q <= '0;
      lol_q     <= '0;
    end else begin
      win_bit_q <= win_bit_d;
      win_err_q <= win_err_d;
      lol_q     <= lol_d;
    end
  end

  always_comb begin
    lol_count = lol_q;
  end
`else
  always_comb begin
    lol_count  = '0;
    unused_cfg = (WINDOW_LEN == 0) ^ (LOL_THRESHOLD == 0);
  end
`endif

  always_comb begin
    locked           = (state_q == LOCKED);
    error_pulse      = err_pulse_q;
    total_bits       = bits_q;
    total_bit_errors = errs_q;
  end

endmodule

// File: tb/tb_prbs_lock_checker.sv
// Directed bench for prbs_lock_checker: acquisition, error counting, window
// loss of lock (when PRBS_LOCK_CHECKER_LOL_EN is defined), saturation, clear, prbs_sel.
module tb_prbs_lock_checker;

  logic        clk = 1'b0;
  logic        rst, clear, data_in, data_in_valid;
  logic [1:0]  prbs_sel;
  logic        locked, error_pulse;
  logic [31:0] total_bits, total_bit_errors;
  logic [15:0] lol_count;
  logic        sm_locked, sm_error_pulse;
  logic [3:0]  sm_bits, sm_errs;
  logic [15:0] sm_lol;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;

  logic [30:0] gen_q;
  int unsigned exp_bits, exp_errs, win_pos;
  bit          m_locked;
  int unsigned rec_bits, rec_errs, rec_lol;

  always #5 clk = ~clk;

  prbs_lock_checker u_dut (
    .clk (clk), .rst (rst), .prbs_sel (prbs_sel), .clear (clear),
    .data_in (data_in), .data_in_valid (data_in_valid),
    .locked (locked), .error_pulse (error_pulse), .total_bits (total_bits),
    .total_bit_errors (total_bit_errors), .lol_count (lol_count)
  );

  prbs_lock_checker #(.COUNT_WIDTH(4)) u_small (
    .clk (clk), .rst (rst), .prbs_sel (prbs_sel), .clear (clear),
    .data_in (data_in), .data_in_valid (data_in_valid),
    .locked (sm_locked), .error_pulse (sm_error_pulse), .total_bits (sm_bits),
    .total_bit_errors (sm_errs), .lol_count (sm_lol)
  );

  // Reference sequence: x^7+x^6+1, x^15+x^14+1, x^23+x^18+1, x^31+x^28+1.
  function automatic logic gen_fb(input logic [30:0] g, input logic [1:0] s);
    case (s)
      2'd0:    return g[6] ^ g[5];
      2'd1:    return g[14] ^ g[13];
      2'd2:    return g[22] ^ g[17];
      default: return g[30] ^ g[27];
    endcase
  endfunction

  task automatic send_bit(input bit flip, input bit with_clear = 1'b0);
    logic nb;
    nb            = gen_fb(gen_q, prbs_sel);
    gen_q         = {gen_q[29:0], nb};
    data_in       = nb ^ flip;
    data_in_valid = 1'b1;
    clear         = with_clear;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
    clear         = 1'b0;
    if (m_locked) begin
      exp_bits++;
      if (flip) exp_errs++;
      win_pos = (win_pos + 1) % 64;
    end
    if (with_clear) begin
      exp_bits = 0;
      exp_errs = 0;
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_clean(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic do_reset(input logic [1:0] sel);
    prbs_sel      = sel;
    rst           = 1'b1;
    clear         = 1'b0;
    data_in       = 1'b0;
    data_in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    gen_q    = '1;
    exp_bits = 0;
    exp_errs = 0;
    win_pos  = 0;
    m_locked = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(2'd3);
    tests_run++;
    if (locked !== 1'b0 || error_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: locked=%b pulse=%b expected 0 0", locked, error_pulse);
    end
    tests_run++;
    if (total_bits !== 32'd0 || total_bit_errors !== 32'd0 || lol_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_counts: bits=%0d errs=%0d lol=%0d expected 0", total_bits, total_bit_errors, lol_count);
    end
    tests_run++;
    if (sm_bits !== 4'd0 || sm_errs !== 4'd0 || sm_lol !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_small: bits=%0d errs=%0d lol=%0d expected 0", sm_bits, sm_errs, sm_lol);
    end
  endtask

  task automatic test_clean_lock();
    send_clean(62);
    tests_run++;
    if (locked !== 1'b0) begin
      tests_failed++;
      $display("FAIL lock_early: locked=%b after 62 bits, expected 0", locked);
    end
    send_bit(1'b0);
    tests_run++;
    if (locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL lock_at_63: locked=%b expected 1", locked);
    end
    m_locked = 1'b1;
    win_pos  = 0;
    send_clean(1000);
    tests_run++;
    if (total_bits !== 32'd1000 || total_bit_errors !== 32'd0) begin
      tests_failed++;
      $display("FAIL clean_1000: bits=%0d errs=%0d expected 1000 0", total_bits, total_bit_errors);
    end
  endtask

  task automatic test_single_error();
    send_clean(499);
    send_bit(1'b1);
    tests_run++;
    if (error_pulse !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_pulse: error_pulse=%b expected 1", error_pulse);
    end
    send_bit(1'b0);
    tests_run++;
    if (error_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_pulse_end: error_pulse=%b expected 0", error_pulse);
    end
    tests_run++;
    if (total_bit_errors !== 32'd1 || total_bits !== 32'd1501 || locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_counts: errs=%0d bits=%0d locked=%b expected 1 1501 1", total_bit_errors, total_bits, locked);
    end
  endtask

  // 7 errors at the end of one window and 7 at the start of the next.
  task automatic test_window_wrap();
    while (win_pos != 50) send_bit(1'b0);
    for (int unsigned k = 0; k < 28; k++) send_bit(k % 2 == 0);
    tests_run++;
    if (locked !== 1'b1 || lol_count !== 16'd0 || total_bit_errors !== 32'd15) begin
      tests_failed++;
      $display("FAIL window_wrap: locked=%b lol=%0d errs=%0d expected 1 0 15", locked, lol_count, total_bit_errors);
    end
  endtask

  task automatic test_loss_of_lock();
    while (win_pos != 0) send_bit(1'b0);
    for (int unsigned k = 0; k < 14; k++) send_bit(k % 2 == 0);
    tests_run++;
    if (locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL lol_seven: locked=%b after 7 window errors, expected 1", locked);
    end
    send_bit(1'b1);
`ifdef PRBS_LOCK_CHECKER_LOL_EN
    m_locked = 1'b0;
    tests_run++;
    if (locked !== 1'b0 || lol_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL lol_eighth: locked=%b lol=%0d expected 0 1", locked, lol_count);
    end
    send_clean(62);
    tests_run++;
    if (locked !== 1'b0 || total_bits !== exp_bits || total_bit_errors !== 32'd23) begin
      tests_failed++;
      $display("FAIL relock_wait: locked=%b bits=%0d errs=%0d expected 0 %0d 23", locked, total_bits, total_bit_errors, exp_bits);
    end
    send_bit(1'b0);
    m_locked = 1'b1;
    win_pos  = 0;
    tests_run++;
    if (locked !== 1'b1 || lol_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL relock: locked=%b lol=%0d expected 1 1", locked, lol_count);
    end
`else
    tests_run++;
    if (locked !== 1'b1 || lol_count !== 16'd0 || total_bit_errors !== 32'd23) begin
      tests_failed++;
      $display("FAIL no_lol: locked=%b lol=%0d errs=%0d expected 1 0 23", locked, lol_count, total_bit_errors);
    end
`endif
  endtask

  // Eighth error lands on the window's wrap bit: loss of lock must still win.
  task automatic test_wrap_lol();
    while (win_pos != 49) send_bit(1'b0);
    for (int unsigned k = 0; k < 15; k++) send_bit(k % 2 == 0);
`ifdef PRBS_LOCK_CHECKER_LOL_EN
    tests_run++;
    if (locked !== 1'b0 || lol_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL wrap_lol: locked=%b lol=%0d expected 0 2", locked, lol_count);
    end
`else
    tests_run++;
    if (locked !== 1'b1 || lol_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL wrap_no_lol: locked=%b lol=%0d expected 1 0", locked, lol_count);
    end
`endif
  endtask

  task automatic test_verify_flip();
    do_reset(2'd3);
    send_clean(31 + 9);
    send_bit(1'b1);
    tests_run++;
    if (locked !== 1'b0 || total_bits !== 32'd0) begin
      tests_failed++;
      $display("FAIL verify_flip: locked=%b bits=%0d expected 0 0", locked, total_bits);
    end
    send_clean(62);
    tests_run++;
    if (locked !== 1'b0 || total_bits !== 32'd0 || total_bit_errors !== 32'd0) begin
      tests_failed++;
      $display("FAIL verify_relock_early: locked=%b bits=%0d errs=%0d expected 0 0 0", locked, total_bits, total_bit_errors);
    end
    send_bit(1'b0);
    tests_run++;
    if (locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL verify_relock: locked=%b expected 1", locked);
    end
  endtask

  task automatic test_saturation_clear();
    do_reset(2'd3);
    send_clean(63);
    m_locked = 1'b1;
    for (int unsigned k = 0; k < 20; k++) send_bit(k == 3 || k == 7);
    tests_run++;
    if (sm_bits !== 4'd15 || sm_errs !== 4'd2 || sm_locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL saturate: bits=%0d errs=%0d locked=%b expected 15 2 1", sm_bits, sm_errs, sm_locked);
    end
    tests_run++;
    if (total_bits !== 32'd20 || total_bit_errors !== 32'd2) begin
      tests_failed++;
      $display("FAIL wide_counts: bits=%0d errs=%0d expected 20 2", total_bits, total_bit_errors);
    end
    send_bit(1'b1, 1'b1);
    tests_run++;
    if (sm_bits !== 4'd0 || sm_errs !== 4'd0 || total_bits !== 32'd0 || total_bit_errors !== 32'd0) begin
      tests_failed++;
      $display("FAIL clear_wins: sbits=%0d serrs=%0d bits=%0d errs=%0d expected 0", sm_bits, sm_errs, total_bits, total_bit_errors);
    end
    tests_run++;
    if (error_pulse !== 1'b1 || sm_error_pulse !== 1'b1 || locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL clear_pulse: pulse=%b spulse=%b locked=%b expected 1 1 1", error_pulse, sm_error_pulse, locked);
    end
  endtask

  task automatic test_reset_midlock();
    send_clean(10);
    rst      = 1'b1;
    clear    = 1'b1;
    prbs_sel = 2'd1;
    idle_cycle();
    rst   = 1'b0;
    clear = 1'b0;
    tests_run++;
    if (locked !== 1'b0 || total_bits !== 32'd0 || error_pulse !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_midlock: locked=%b bits=%0d pulse=%b expected 0 0 0", locked, total_bits, error_pulse);
    end
  endtask

  // PRBS7 lock, 100 locked bits with one error, then prbs_sel switched to 3.
  task automatic run_sel_change(input bit gapped);
    do_reset(2'd0);
    for (int unsigned i = 0; i < 39; i++) begin
      send_bit(1'b0);
      if (gapped) idle_cycle();
    end
    tests_run++;
    if (locked !== 1'b1) begin
      tests_failed++;
      $display("FAIL prbs7_lock: locked=%b gapped=%0d expected 1", locked, gapped);
    end
    m_locked = 1'b1;
    for (int unsigned i = 0; i < 100; i++) begin
      send_bit(i == 40);
      if (gapped) idle_cycle();
      if (gapped && i == 40) begin
        tests_run++;
        if (error_pulse !== 1'b0 || total_bit_errors !== 32'd1 || total_bits !== 32'd41) begin
          tests_failed++;
          $display("FAIL gap_hold: pulse=%b errs=%0d bits=%0d expected 0 1 41", error_pulse, total_bit_errors, total_bits);
        end
      end
    end
    prbs_sel = 2'd3;
    idle_cycle();
    tests_run++;
    if (locked !== 1'b0 || lol_count !== 16'd0 || total_bits !== 32'd100 || total_bit_errors !== 32'd1) begin
      tests_failed++;
      $display("FAIL sel_change: locked=%b lol=%0d bits=%0d errs=%0d expected 0 0 100 1", locked, lol_count, total_bits, total_bit_errors);
    end
  endtask

  task automatic test_sel_change();
    run_sel_change(1'b0);
    rec_bits = total_bits;
    rec_errs = total_bit_errors;
    rec_lol  = lol_count;
    run_sel_change(1'b1);
    tests_run++;
    if (total_bits !== rec_bits || total_bit_errors !== rec_errs || lol_count !== rec_lol[15:0]) begin
      tests_failed++;
      $display("FAIL gapped_same: bits=%0d errs=%0d lol=%0d expected %0d %0d %0d", total_bits, total_bit_errors, lol_count, rec_bits, rec_errs, rec_lol);
    end
  endtask

  initial begin
    test_reset();
    test_clean_lock();
    test_single_error();
    test_window_wrap();
    test_loss_of_lock();
    test_wrap_lol();
    test_verify_flip();
    test_saturation_clear();
    test_reset_midlock();
    test_sel_change();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
